// File: rtl/alu_share_if.sv
// Bundles the requester handshakes, response handshakes and ALU operand bus
// of the shared-ALU arbiter. slave = arbiter side, master = requesters + ALU.
interface alu_share_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     req0_valid, req0_ready;
    logic [OPCODE_LENGTH-1:0] req0_op;
    logic [DATA_WIDTH-1:0]    req0_a, req0_b;
    logic                     req1_valid, req1_ready;
    logic [OPCODE_LENGTH-1:0] req1_op;
    logic [DATA_WIDTH-1:0]    req1_a, req1_b;

    logic                     rsp0_valid, rsp0_ready, rsp0_err;
    logic [DATA_WIDTH-1:0]    rsp0_data;
    logic                     rsp1_valid, rsp1_ready, rsp1_err;
    logic [DATA_WIDTH-1:0]    rsp1_data;

    logic [DATA_WIDTH-1:0]    alu_SrcA, alu_SrcB, alu_Result;
    logic [OPCODE_LENGTH-1:0] alu_Operation;

    logic                     busy, owner;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_err,
        output rsp1_valid, rsp1_data, rsp1_err,
        input  rsp0_ready, rsp1_ready,
        output alu_SrcA, alu_SrcB, alu_Operation,
        input  alu_Result,
        output busy, owner
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_err,
        input  rsp1_valid, rsp1_data, rsp1_err,
        output rsp0_ready, rsp1_ready,
        input  alu_SrcA, alu_SrcB, alu_Operation,
        output alu_Result,
        input  busy, owner
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold result).
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    alu_share_if.slave  bus
);
    localparam logic [OPCODE_LENGTH-1:0] OP_NOP = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_JAL = OPCODE_LENGTH'(4'b1111);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     rr_ptr_q, rr_ptr_d;
    logic                     owner_q, owner_d;
    logic                     err_q, err_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic [OPCODE_LENGTH-1:0] alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;

    logic grant, req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [OPCODE_LENGTH-1:0] sel_op;

    // Next-state, grant selection and handshake outputs
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        err_d      = err_q;
        op_d       = op_q;
        alu_op_d   = alu_op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        grant      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        sel_op     = bus.req0_op;
        case (state_q)
            IDLE: begin
                // Contention resolved by rr_ptr; otherwise the lone requester wins
                grant      = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
                req0_ready = bus.req0_valid && !grant;
                req1_ready = bus.req1_valid && grant;
                sel_op     = grant ? bus.req1_op : bus.req0_op;
                if (req0_ready || req1_ready) begin
                    op_d     = sel_op;
                    a_d      = grant ? bus.req1_a : bus.req0_a;
                    b_d      = grant ? bus.req1_b : bus.req0_b;
                    // Unsupported JAL/JALR never reaches the ALU; it sees a no-op
                    alu_op_d = (sel_op == OP_JAL) ? OP_NOP : sel_op;
                    owner_d  = grant;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (op_q == OP_JAL) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end else begin
                    result_d = bus.alu_Result;
                    err_d    = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
                    rr_ptr_d = ~owner_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            err_q    <= 1'b0;
            op_q     <= '0;
            alu_op_q <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
            op_q     <= op_d;
            alu_op_q <= alu_op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign bus.req0_ready    = req0_ready;
    assign bus.req1_ready    = req1_ready;
    assign bus.rsp0_valid    = rsp0_valid;
    assign bus.rsp1_valid    = rsp1_valid;
    assign bus.rsp0_data     = result_q;
    assign bus.rsp1_data     = result_q;
    assign bus.rsp0_err      = err_q;
    assign bus.rsp1_err      = err_q;
    assign bus.alu_SrcA      = a_q;
    assign bus.alu_SrcB      = b_q;
    assign bus.alu_Operation = alu_op_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.owner         = owner_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small combinational ALU model.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    alu_share_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

    alu_share_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ALU stand-in: add, sub, xor; anything else yields 0
    always_comb begin
        case (bus.alu_Operation)
            4'b0000: bus.alu_Result = bus.alu_SrcA + bus.alu_SrcB;
            4'b0001: bus.alu_Result = bus.alu_SrcA - bus.alu_SrcB;
            4'b0010: bus.alu_Result = bus.alu_SrcA ^ bus.alu_SrcB;
            default: bus.alu_Result = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_req(input bit r, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (r) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    // Single uncontended op with response ready: accept, EXEC, RESP
    task automatic do_op(input string tag, input bit r, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input logic exp_err);
        set_req(r, 1'b1, op, a, b);
        @(negedge clk);
        chk({tag, "_ready"}, r ? bus.req1_ready : bus.req0_ready, 1);
        step();
        set_req(r, 1'b0, 4'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk({tag, "_exec_busy"}, bus.busy, 1);
        chk({tag, "_exec_owner"}, bus.owner, r);
        step();
        @(negedge clk);
        chk({tag, "_rsp_valid"}, r ? bus.rsp1_valid : bus.rsp0_valid, 1);
        chk({tag, "_other_valid"}, r ? bus.rsp0_valid : bus.rsp1_valid, 0);
        chk({tag, "_data"}, r ? bus.rsp1_data : bus.rsp0_data, exp_data);
        chk({tag, "_err"}, r ? bus.rsp1_err : bus.rsp0_err, exp_err);
        step();
    endtask

    logic [31:0] t3_a0 [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
    logic [31:0] t3_b0 [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
    logic [31:0] t3_e0 [4] = '{32'd11, 32'd22, 32'd33, 32'd44};
    logic [31:0] t3_a1 [4] = '{32'd50, 32'd60, 32'd70, 32'd80};
    logic [31:0] t3_b1 [4] = '{32'd5, 32'd6, 32'd7, 32'd8};
    logic [31:0] t3_e1 [4] = '{32'd45, 32'd54, 32'd63, 32'd72};

    initial begin
        reset = 1'b0;
        set_req(0, 1'b0, 4'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'b0, 32'd0, 32'd0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        step();
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_aluop", bus.alu_Operation, 4'b1001);
        chk("rst_srca", bus.alu_SrcA, 0);
        chk("rst_rsp0v", bus.rsp0_valid, 0);
        chk("rst_rsp1v", bus.rsp1_valid, 0);
        chk("rst_req0r", bus.req0_ready, 0);
        chk("rst_owner", bus.owner, 0);
        step();

        // 1: simple add on requester 0
        do_op("t1", 0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);
        @(negedge clk);
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_idle_rsp0v", bus.rsp0_valid, 0);
        step();

        // 2: simultaneous requests after reset, req0 first
        do_reset();
        set_req(0, 1'b1, 4'b0001, 32'd10, 32'd3);
        set_req(1, 1'b1, 4'b0010, 32'hF0, 32'h0F);
        @(negedge clk);
        chk("t2_r0_ready", bus.req0_ready, 1);
        chk("t2_r1_ready", bus.req1_ready, 0);
        step();
        set_req(0, 1'b0, 4'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t2_owner0", bus.owner, 0);
        chk("t2_exec_r1_ready", bus.req1_ready, 0);
        step();
        @(negedge clk);
        chk("t2_rsp0_valid", bus.rsp0_valid, 1);
        chk("t2_rsp0_data", bus.rsp0_data, 32'd7);
        step();
        set_req(1, 1'b0, 4'b0, 32'd0, 32'd0);
        do_op("t2b", 1, 4'b0010, 32'hF0, 32'h0F, 32'hFF, 1'b0);

        // 3: both held valid, strict alternation, 3 cycles per op
        do_reset();
        set_req(0, 1'b1, 4'b0000, t3_a0[0], t3_b0[0]);
        set_req(1, 1'b1, 4'b0001, t3_a1[0], t3_b1[0]);
        for (int k = 0; k < 8; k++) begin
            bit r;
            int idx;
            r   = k[0];
            idx = k / 2;
            @(negedge clk);
            chk($sformatf("t3_grant%0d_sel", k), r ? bus.req1_ready : bus.req0_ready, 1);
            chk($sformatf("t3_grant%0d_oth", k), r ? bus.req0_ready : bus.req1_ready, 0);
            step();
            if (idx < 3) begin
                if (r) set_req(1, 1'b1, 4'b0001, t3_a1[idx+1], t3_b1[idx+1]);
                else   set_req(0, 1'b1, 4'b0000, t3_a0[idx+1], t3_b0[idx+1]);
            end else begin
                set_req(r, 1'b0, 4'b0, 32'd0, 32'd0);
            end
            @(negedge clk);
            chk($sformatf("t3_owner%0d", k), bus.owner, r);
            step();
            @(negedge clk);
            chk($sformatf("t3_rspv%0d", k), r ? bus.rsp1_valid : bus.rsp0_valid, 1);
            chk($sformatf("t3_data%0d", k), r ? bus.rsp1_data : bus.rsp0_data,
                r ? t3_e1[idx] : t3_e0[idx]);
            step();
        end

        // 4: response backpressure blocks the other requester
        do_reset();
        bus.rsp0_ready = 1'b0;
        set_req(0, 1'b1, 4'b0000, 32'd1, 32'd1);
        set_req(1, 1'b1, 4'b0000, 32'd2, 32'd2);
        @(negedge clk);
        chk("t4_r0_ready", bus.req0_ready, 1);
        chk("t4_r1_ready", bus.req1_ready, 0);
        step();
        set_req(0, 1'b0, 4'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t4_exec_r1_ready", bus.req1_ready, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t4_hold_v%0d", i), bus.rsp0_valid, 1);
            chk($sformatf("t4_hold_d%0d", i), bus.rsp0_data, 32'd2);
            chk($sformatf("t4_hold_r1_%0d", i), bus.req1_ready, 0);
            step();
        end
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        chk("t4_hs_valid", bus.rsp0_valid, 1);
        chk("t4_hs_r1_ready", bus.req1_ready, 0);
        step();
        @(negedge clk);
        chk("t4_r1_granted", bus.req1_ready, 1);
        step();
        set_req(1, 1'b0, 4'b0, 32'd0, 32'd0);
        step();
        @(negedge clk);
        chk("t4_rsp1_valid", bus.rsp1_valid, 1);
        chk("t4_rsp1_data", bus.rsp1_data, 32'd4);
        step();

        // 5: unsupported opcode on requester 1
        set_req(1, 1'b1, 4'b1111, 32'd3, 32'd4);
        @(negedge clk);
        chk("t5_ready", bus.req1_ready, 1);
        step();
        set_req(1, 1'b0, 4'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("t5_exec_aluop", bus.alu_Operation, 4'b1001);
        step();
        @(negedge clk);
        chk("t5_rsp1_valid", bus.rsp1_valid, 1);
        chk("t5_rsp1_data", bus.rsp1_data, 32'd0);
        chk("t5_rsp1_err", bus.rsp1_err, 1);
        step();

        // 6: reset during EXEC discards the op and restores rr_ptr
        do_op("t6a", 0, 4'b0000, 32'd20, 32'd22, 32'd42, 1'b0);
        set_req(0, 1'b1, 4'b0000, 32'd9, 32'd9);
        @(negedge clk);
        chk("t6_ready", bus.req0_ready, 1);
        step();
        set_req(0, 1'b0, 4'b0, 32'd0, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_exec_busy", bus.busy, 1);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_busy", bus.busy, 0);
        chk("t6_rsp0v", bus.rsp0_valid, 0);
        chk("t6_aluop", bus.alu_Operation, 4'b1001);
        set_req(0, 1'b1, 4'b0000, 32'd100, 32'd23);
        set_req(1, 1'b1, 4'b0000, 32'd1, 32'd1);
        #1;
        chk("t6_rr_r0", bus.req0_ready, 1);
        chk("t6_rr_r1", bus.req1_ready, 0);
        step();
        set_req(0, 1'b0, 4'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'b0, 32'd0, 32'd0);
        step();
        @(negedge clk);
        chk("t6_rsp0_valid", bus.rsp0_valid, 1);
        chk("t6_rsp0_data", bus.rsp0_data, 32'd123);
        chk("t6_rsp0_err", bus.rsp0_err, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single ALU between two requesters, e.g. the main execute path and an address/compare helper unit, using valid/ready handshakes on both the request and response sides. Grants round-robin, registers the operands, drives the ALU operand and opcode inputs, captures the result and returns it to the owning requester. Only one operation is in flight at a time.

Parameters:
DATA_WIDTH, 32, operand/result width
OPCODE_LENGTH, 4, ALU operation code width

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  OPCODE_LENGTH  requester 0 ALU opcode
req0_a  in  DATA_WIDTH  requester 0 operand A
req0_b  in  DATA_WIDTH  requester 0 operand B
req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 takes result
rsp0_data  out  DATA_WIDTH  result for requester 0
rsp0_err  out  1  unsupported opcode flag for requester 0
rsp1_valid / rsp1_ready / rsp1_data / rsp1_err  same as rsp0_*, for requester 1
alu_SrcA  out  DATA_WIDTH  to ALU SrcA
alu_SrcB  out  DATA_WIDTH  to ALU SrcB
alu_Operation  out  OPCODE_LENGTH  to ALU Operation
alu_Result  in  DATA_WIDTH  from ALU ALUResult
busy  out  1  state is not IDLE
owner  out  1  requester currently served; valid only while busy

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset values: state IDLE; rr_ptr 0; operand, opcode and result registers 0; owner 0; err 0. All rsp*_valid, req*_ready and busy are 0. alu_Operation resets to 4'b1001, the no-op code.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - Only req0_valid high: grant 0. Only req1_valid high: grant 1. Both high: grant rr_ptr.
  - reqN_ready is combinational and high only in IDLE, only for the granted N.
  - On the handshake: latch op/a/b into registers, set owner=N, go to EXEC.
- EXEC (exactly 1 cycle):
  - Registered operands and opcode drive alu_SrcA, alu_SrcB and alu_Operation.
  - alu_Result is captured into the result register at the end of the cycle. Go to RESP.
  - Opcode 4'b1111 (JAL/JALR) is not supported: alu_Operation stays 4'b1001, result = 0, err = 1.
- RESP:
  - rsp[owner]_valid = 1; rsp_data and rsp_err are held stable until rsp[owner]_ready.
  - On the handshake: rr_ptr = ~owner, go to IDLE.
  - The non-owner's rsp_valid stays 0.
- ALU inputs hold their last registered values outside EXEC. The ALU path is purely combinational, so result capture in EXEC is valid.
- Latency: request accepted at cycle N gives rsp_valid at N+2 (the result is captured at the end of N+1). Peak throughput is 1 op per 3 cycles.
- Rules for requesters:
  - Hold valid and payload stable until ready.
  - Requests are not accepted in EXEC or RESP, however long response backpressure lasts.
- Fairness: both valid continuously with immediate rsp_ready gives strictly alternating grants.
- Data widths: operands and results pass through unmodified. No sign or width conversion in this block.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response. The next cycle is IDLE with reset values.
- A requester may drop valid while not yet granted. No grant results and no state change.

Test Plan:
1. req0 op 0000, a=5, b=7, rsp0_ready=1 -> req0_ready in accept cycle N; rsp0_valid at N+2, rsp0_data=12, rsp0_err=0; busy high N+1..N+2; rsp1_valid never high.
2. After reset, both valid at once: req0 op 0001 (10-3), req1 op 0010 (0xF0^0x0F) -> req0 served first with data 7; then req1 with data 0xFF; owner goes 0 then 1.
3. Both requesters held valid for 4 ops each, rsp ready high -> grant order 0,1,0,1,0,1,0,1; each result correct; 3 cycles per op.
4. req0 op 0000 (1+1), rsp0_ready low 5 cycles, req1 valid throughout -> rsp0_valid=1 and data=2 stable all 5 cycles; req1_ready=0 until the cycle after the rsp0 handshake; then req1 is granted.
5. req1 op 1111, a=3, b=4 -> alu_Operation stays 1001; rsp1_data=0, rsp1_err=1 at N+2.
6. reset asserted 1 cycle during EXEC of a req0 op -> no rsp0_valid; next cycle busy=0, alu_Operation=1001, rr_ptr=0; a following req0 op completes normally.
